// File: rtl/mul_dot_seq_if.sv
// Bundle of the operand-pair input stream, the multiplier start/busy/y link and
// the result output stream of the dot-product sequencer.
interface mul_dot_seq_if #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [7:0]       in_a_i;
    logic [7:0]       in_b_i;
    logic             in_last_i;
    logic             mul_start_o;
    logic [7:0]       mul_a_o;
    logic [7:0]       mul_b_o;
    logic             mul_busy_i;
    logic [15:0]      mul_y_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [ACC_W-1:0] out_sum_o;
    logic [CNT_W-1:0] out_cnt_o;
    logic             out_ovf_o;
    logic             err_o;

    modport slave (
        input  in_valid_i, in_a_i, in_b_i, in_last_i, mul_busy_i, mul_y_i, out_ready_i,
        output in_ready_o, mul_start_o, mul_a_o, mul_b_o,
               out_valid_o, out_sum_o, out_cnt_o, out_ovf_o, err_o
    );

    modport master (
        output in_valid_i, in_a_i, in_b_i, in_last_i, mul_busy_i, mul_y_i, out_ready_i,
        input  in_ready_o, mul_start_o, mul_a_o, mul_b_o,
               out_valid_o, out_sum_o, out_cnt_o, out_ovf_o, err_o
    );
endinterface

// File: rtl/mul_dot_seq.sv
// Dot-product sequencer feeding a start/busy/y multiplier; accepts one pair per multiply
// (in_ready only in IDLE), result held on out_valid until out_ready; watchdog on a dead multiplier.
module mul_dot_seq #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 8,
    parameter int TMO   = 15
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mul_dot_seq_if.slave  bus
);
    localparam int WD_W = $clog2(TMO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_OUT
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             last_q, last_d;
    logic [7:0]       mul_a_q, mul_a_d;
    logic [7:0]       mul_b_q, mul_b_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [ACC_W:0]   sum_ext;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            last_q  <= last_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        last_d  = last_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        wd_d    = wd_q;
        // Extra top bit is the wrap-around carry of this accumulation.
        sum_ext = {1'b0, acc_q} + {{(ACC_W - 15){1'b0}}, bus.mul_y_i};

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid_i) begin
                    mul_a_d = bus.in_a_i;
                    mul_b_d = bus.in_b_i;
                    last_d  = bus.in_last_i;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (bus.mul_busy_i) begin
                    state_d = S_WAIT_LO;
                end else begin
                    wd_d = wd_q + 1'b1;
                    // Dead multiplier: drop this pair but still close a last-flagged product.
                    if (wd_d == WD_W'(TMO)) begin
                        err_d   = 1'b1;
                        state_d = last_q ? S_OUT : S_IDLE;
                    end
                end
            end
            S_WAIT_LO: begin
                if (!bus.mul_busy_i) begin
                    acc_d   = sum_ext[ACC_W-1:0];
                    ovf_d   = ovf_q | sum_ext[ACC_W];
                    cnt_d   = cnt_q + 1'b1;
                    state_d = last_q ? S_OUT : S_IDLE;
                end
            end
            S_OUT: begin
                if (bus.out_ready_i) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.in_ready_o  = (state_q == S_IDLE);
    assign bus.mul_start_o = (state_q == S_ISSUE);
    assign bus.out_valid_o = (state_q == S_OUT);
    assign bus.mul_a_o     = mul_a_q;
    assign bus.mul_b_o     = mul_b_q;
    assign bus.out_sum_o   = acc_q;
    assign bus.out_cnt_o   = cnt_q;
    assign bus.out_ovf_o   = ovf_q;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_mul_dot_seq.sv
// Directed bench for mul_dot_seq: a 24-bit instance for most cases and a 16-bit one for wrap,
// each driven by a behavioural 8-cycle multiplier.
module tb_mul_dot_seq;
    logic clk;
    logic rst_n;

    logic       sel;
    logic       in_valid;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       in_last;
    logic       out_ready;
    logic       mul_dead;

    int n_chk;
    int n_pass;

    mul_dot_seq_if #(.ACC_W(24), .CNT_W(8)) ifa ();
    mul_dot_seq_if #(.ACC_W(16), .CNT_W(8)) ifb ();

    mul_dot_seq #(.ACC_W(24), .CNT_W(8), .TMO(15)) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifa.slave)
    );

    mul_dot_seq #(.ACC_W(16), .CNT_W(8), .TMO(15)) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ifa.in_valid_i  = in_valid & ~sel;
    assign ifb.in_valid_i  = in_valid & sel;
    assign ifa.in_a_i      = in_a;
    assign ifb.in_a_i      = in_a;
    assign ifa.in_b_i      = in_b;
    assign ifb.in_b_i      = in_b;
    assign ifa.in_last_i   = in_last;
    assign ifb.in_last_i   = in_last;
    assign ifa.out_ready_i = out_ready;
    assign ifb.out_ready_i = out_ready;

    // Behavioural multipliers: busy for 8 cycles after a start, product ready when busy falls.
    logic        busy_a, busy_b;
    logic [3:0]  mc_a, mc_b;
    logic [15:0] y_a, y_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_a <= 1'b0; mc_a <= 4'd0; y_a <= 16'd0;
        end else if (ifa.mul_start_o && !mul_dead) begin
            busy_a <= 1'b1; mc_a <= 4'd8; y_a <= ifa.mul_a_o * ifa.mul_b_o;
        end else if (mc_a != 4'd0) begin
            mc_a <= mc_a - 4'd1;
            if (mc_a == 4'd1) busy_a <= 1'b0;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_b <= 1'b0; mc_b <= 4'd0; y_b <= 16'd0;
        end else if (ifb.mul_start_o && !mul_dead) begin
            busy_b <= 1'b1; mc_b <= 4'd8; y_b <= ifb.mul_a_o * ifb.mul_b_o;
        end else if (mc_b != 4'd0) begin
            mc_b <= mc_b - 4'd1;
            if (mc_b == 4'd1) busy_b <= 1'b0;
        end
    end

    assign ifa.mul_busy_i = busy_a;
    assign ifa.mul_y_i    = y_a;
    assign ifb.mul_busy_i = busy_b;
    assign ifb.mul_y_i    = y_b;

    logic        o_in_ready, o_start, o_valid, o_ovf, o_err;
    logic [7:0]  o_mul_a, o_mul_b, o_cnt;
    logic [23:0] o_sum;

    assign o_in_ready = sel ? ifb.in_ready_o  : ifa.in_ready_o;
    assign o_start    = sel ? ifb.mul_start_o : ifa.mul_start_o;
    assign o_valid    = sel ? ifb.out_valid_o : ifa.out_valid_o;
    assign o_ovf      = sel ? ifb.out_ovf_o   : ifa.out_ovf_o;
    assign o_err      = sel ? ifb.err_o       : ifa.err_o;
    assign o_mul_a    = sel ? ifb.mul_a_o     : ifa.mul_a_o;
    assign o_mul_b    = sel ? ifb.mul_b_o     : ifa.mul_b_o;
    assign o_cnt      = sel ? ifb.out_cnt_o   : ifa.out_cnt_o;
    assign o_sum      = sel ? {8'd0, ifb.out_sum_o} : ifa.out_sum_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Present one pair, wait for acceptance, then look at the ISSUE cycle.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
        int k;
        @(negedge clk);
        k = 0;
        while (!o_in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("in_ready_timeout", 32'(k), 32'd0);
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("issue_start", {31'd0, o_start}, 32'd1);
        chk("issue_mul_a", {24'd0, o_mul_a}, {24'd0, a});
        chk("issue_mul_b", {24'd0, o_mul_b}, {24'd0, b});
    endtask

    // Called at the ISSUE-cycle negedge; returns cycles from the accept cycle to out_valid.
    task automatic wait_out(output int lat);
        int k;
        k = 1;
        while (!o_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk("out_valid_timeout", 32'(k), 32'd0);
        lat = k;
    endtask

    task automatic take_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        n_chk = 0; n_pass = 0;
        sel = 1'b0; in_valid = 1'b0; in_a = 8'd0; in_b = 8'd0; in_last = 1'b0;
        out_ready = 1'b0; mul_dead = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  {31'd0, o_in_ready}, 32'd1);
        chk("rst_start",     {31'd0, o_start},    32'd0);
        chk("rst_out_valid", {31'd0, o_valid},    32'd0);
        chk("rst_sum",       {8'd0, o_sum},       32'd0);
        chk("rst_err",       {31'd0, o_err},      32'd0);
        rst_n = 1'b1;

        // Single pair 3*5
        send(8'd3, 8'd5, 1'b1);
        chk("t1_in_ready_busy", {31'd0, o_in_ready}, 32'd0);
        wait_out(lat);
        chk("t1_latency", 32'(lat), 32'd11);
        chk("t1_sum", {8'd0, o_sum}, 32'd15);
        chk("t1_cnt", {24'd0, o_cnt}, 32'd1);
        chk("t1_ovf", {31'd0, o_ovf}, 32'd0);
        take_out();
        @(negedge clk);
        chk("t1_idle_after", {31'd0, o_in_ready}, 32'd1);

        // Three pairs: 2 + 12 + 30
        send(8'd1, 8'd2, 1'b0);
        send(8'd3, 8'd4, 1'b0);
        send(8'd5, 8'd6, 1'b1);
        wait_out(lat);
        chk("t2_sum", {8'd0, o_sum}, 32'd44);
        chk("t2_cnt", {24'd0, o_cnt}, 32'd3);

        // Consumer stalls for 5 cycles
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", {31'd0, o_valid},    32'd1);
            chk("t4_hold_sum",   {8'd0, o_sum},       32'd44);
            chk("t4_hold_ready", {31'd0, o_in_ready}, 32'd0);
        end
        take_out();
        send(8'd2, 8'd3, 1'b1);
        wait_out(lat);
        chk("t4_fresh_sum", {8'd0, o_sum}, 32'd6);
        chk("t4_fresh_cnt", {24'd0, o_cnt}, 32'd1);
        take_out();

        // 16-bit accumulator wrap: 2*65025 mod 65536
        sel = 1'b1;
        send(8'd255, 8'd255, 1'b0);
        send(8'd255, 8'd255, 1'b1);
        wait_out(lat);
        chk("t3_sum", {8'd0, o_sum}, 32'd64514);
        chk("t3_cnt", {24'd0, o_cnt}, 32'd2);
        chk("t3_ovf", {31'd0, o_ovf}, 32'd1);
        take_out();
        @(negedge clk);
        chk("t3_ovf_cleared", {31'd0, o_ovf}, 32'd0);
        sel = 1'b0;

        // Dead multiplier: watchdog after 15 WAIT_HI cycles
        mul_dead = 1'b1;
        send(8'd7, 8'd7, 1'b1);
        wait_out(lat);
        chk("t5_latency", 32'(lat), 32'd17);
        chk("t5_err", {31'd0, o_err}, 32'd1);
        chk("t5_sum", {8'd0, o_sum}, 32'd0);
        chk("t5_cnt", {24'd0, o_cnt}, 32'd0);
        take_out();
        mul_dead = 1'b0;
        send(8'd4, 8'd4, 1'b1);
        wait_out(lat);
        chk("t5_after_sum", {8'd0, o_sum}, 32'd16);
        chk("t5_err_sticky", {31'd0, o_err}, 32'd1);
        take_out();

        // Async reset during WAIT_LO of the second pair
        send(8'd1, 8'd1, 1'b0);
        send(8'd2, 8'd2, 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_in_ready", {31'd0, o_in_ready}, 32'd1);
        chk("t6_valid",    {31'd0, o_valid},    32'd0);
        chk("t6_mul_a",    {24'd0, o_mul_a},    32'd0);
        chk("t6_err",      {31'd0, o_err},      32'd0);
        chk("t6_sum",      {8'd0, o_sum},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'd2, 8'd2, 1'b1);
        wait_out(lat);
        chk("t6_sum_after", {8'd0, o_sum}, 32'd4);
        chk("t6_cnt_after", {24'd0, o_cnt}, 32'd1);
        take_out();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
